timer_seg_scan: RTL and testbench

Four-digit multiplexed seven-segment display driver sitting directly downstream of the cascaded decade timer digits. It snapshots four BCD counts once per scan frame, decodes them, and blanks leading zeros. It also scans common-anode digits at a programmable rate and latches the most-significant carry as an alarm that blinks the whole display until cleared.

---
 rtl/timer_seg_scan.sv | 170 +++++++++++++++++
 tb/tb_timer_seg_scan.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_seg_scan.sv
// timer_seg_scan: four-digit multiplexed seven-segment driver for the decade
// timer. Snapshots the BCD digits once per scan frame, decodes them with
// optional leading-zero blanking, scans common-anode digits, and latches the
// timer carry as a blinking alarm until it is cleared.
module timer_seg_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 125,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        alarm,
    input  logic        alarm_clr,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        alarm_active
);

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  BLINK_MAX = 8'(BLINK_FRAMES - 1);

    logic [15:0] presc;
    logic [1:0]  idx;
    logic        tick;
    logic        frame_end;

    logic        loaded;
    logic [15:0] shadow_digits;
    logic [3:0]  shadow_dp;

    logic [15:0] src_digits;
    logic [3:0]  src_dp;
    logic [3:0]  cur_digit;
    logic        cur_blank;
    logic [6:0]  cur_seg;

    logic        alarm_r;
    logic        alarm_prev;
    logic        alarm_rise;
    logic        active_nxt;

    logic [7:0]  blink_cnt;
    logic        phase;

    assign tick      = enable && (presc == PRESC_MAX);
    assign frame_end = tick && (idx == 2'd3);

    // Prescaler paces the digit slots; the scan index steps once per slot.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values that existed before the clock edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (!enable) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Shadow copy of the digits, refreshed only at frame boundaries so a frame
    // never mixes old and new values; the first edge after reset primes it.
    // NOTE: the shadow is a handful of flops, not a memory, so it takes the
    // async reset like any other register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            loaded        <= 1'b0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
        end else if (!loaded || frame_end) begin
            loaded        <= 1'b1;
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
        end
    end

    // Select the digit under the scan index, decode it and work out blanking.
    // NOTE: every output of this block gets a default first so no latch forms.
    always_comb begin
        src_digits = loaded ? shadow_digits : digits_in;
        src_dp     = loaded ? shadow_dp : dp_in;
        cur_digit  = src_digits[{idx, 2'b00} +: 4];
        cur_blank  = 1'b0;
        if (BLANK_LZ) begin
            case (idx)
                2'd1:    cur_blank = (src_digits[15:4] == 12'd0);
                2'd2:    cur_blank = (src_digits[15:8] == 8'd0);
                2'd3:    cur_blank = (src_digits[15:12] == 4'd0);
                default: cur_blank = 1'b0;
            endcase
        end
        case (cur_digit)
            4'd0:    cur_seg = 7'h3F;
            4'd1:    cur_seg = 7'h06;
            4'd2:    cur_seg = 7'h5B;
            4'd3:    cur_seg = 7'h4F;
            4'd4:    cur_seg = 7'h66;
            4'd5:    cur_seg = 7'h6D;
            4'd6:    cur_seg = 7'h7D;
            4'd7:    cur_seg = 7'h07;
            4'd8:    cur_seg = 7'h7F;
            4'd9:    cur_seg = 7'h6F;
            default: cur_seg = 7'h40;
        endcase
    end

    // A rising edge of the registered carry sets the alarm; set beats clear.
    assign alarm_rise = alarm_r && !alarm_prev;
    assign active_nxt = alarm_rise || (alarm_active && !alarm_clr);

    // Alarm input history and the alarm latch itself.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            alarm_r      <= 1'b0;
            alarm_prev   <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            alarm_r      <= alarm;
            alarm_prev   <= alarm_r;
            alarm_active <= active_nxt;
        end
    end

    // Blink timer: counts frames while the alarm is up and flips the dark phase.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (alarm_rise || !active_nxt) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!enable) begin
            blink_cnt <= '0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    // Registered display outputs; anode and segments update on the same edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            seg <= '0;
            an  <= 4'hF;
            dp  <= 1'b0;
        end else if (!enable) begin
            seg <= '0;
            an  <= 4'hF;
            dp  <= 1'b0;
        end else begin
            seg <= cur_blank ? 7'h00 : cur_seg;
            an  <= phase ? 4'hF : ~(4'b0001 << idx);
            dp  <= src_dp[idx];
        end
    end

endmodule

// File: tb/tb_timer_seg_scan.sv
// tb_timer_seg_scan: drives two timer_seg_scan instances (leading-zero
// blanking on and off) from shared inputs and compares them against a
// frame-arithmetic reference model plus directed vectors and sequences.
module tb_timer_seg_scan;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in     = 4'h0;
    logic        alarm     = 1'b0;
    logic        alarm_clr = 1'b0;

    logic [6:0] seg_lz, seg_nz;
    logic [3:0] an_lz, an_nz;
    logic       dp_lz, dp_nz;
    logic       act_lz, act_nz;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    timer_seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .BLANK_LZ(1'b1)) dut_lz (
        .Clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
        .dp_in(dp_in), .alarm(alarm), .alarm_clr(alarm_clr),
        .seg(seg_lz), .an(an_lz), .dp(dp_lz), .alarm_active(act_lz)
    );

    timer_seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .BLANK_LZ(1'b0)) dut_nz (
        .Clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
        .dp_in(dp_in), .alarm(alarm), .alarm_clr(alarm_clr),
        .seg(seg_nz), .an(an_nz), .dp(dp_nz), .alarm_active(act_nz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next falling edge; inputs change and
    // directed checks sample here, well away from the rising edge.
    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    task automatic start(input logic [15:0] d, input logic [3:0] p);
        reset     = 1'b1;
        enable    = 1'b0;
        alarm     = 1'b0;
        alarm_clr = 1'b0;
        digits_in = d;
        dp_in     = p;
        nxt();
        nxt();
        enable = 1'b1;
        reset  = 1'b0;
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Scan position, frame boundaries and blink phase are all derived from
    // counts of enabled cycles and completed frames.
    logic [6:0] seg_tab [10];
    initial seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bit          m_loaded;
    int          m_cnt;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    bit          m_a1, m_a2, m_act;
    int          m_frames;
    logic [6:0]  e_seg_lz, e_seg_nz;
    logic [3:0]  e_an;
    logic        e_dp;

    logic [15:0] ms_d;
    logic [3:0]  ms_p;
    logic [3:0]  ms_nib;
    logic [6:0]  ms_full;
    int          ms_slot, ms_ph;
    bit          ms_fe, ms_rise, ms_nact;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_loaded = 0; m_cnt = 0; m_dig = '0; m_dp = '0;
            m_a1 = 0; m_a2 = 0; m_act = 0; m_frames = 0;
            e_seg_lz = '0; e_seg_nz = '0; e_an = 4'hF; e_dp = 1'b0;
        end else begin
            ms_d    = m_loaded ? m_dig : digits_in;
            ms_p    = m_loaded ? m_dp : dp_in;
            ms_slot = (m_cnt / SD) % 4;
            ms_ph   = (m_frames / BF) % 2;
            if (!enable) begin
                e_seg_lz = '0; e_seg_nz = '0; e_an = 4'hF; e_dp = 1'b0;
            end else begin
                ms_nib   = ms_d[4*ms_slot +: 4];
                ms_full  = (ms_nib > 4'd9) ? 7'h40 : seg_tab[ms_nib];
                e_seg_nz = ms_full;
                e_seg_lz = (ms_slot != 0 && (ms_d >> (4*ms_slot)) == 16'd0) ? 7'h00 : ms_full;
                e_an     = (ms_ph != 0) ? 4'hF : ~(4'(1) << ms_slot);
                e_dp     = ms_p[ms_slot];
            end
            ms_fe = enable && (((m_cnt + 1) % (4*SD)) == 0);
            if (!m_loaded || ms_fe) begin
                m_dig = digits_in; m_dp = dp_in; m_loaded = 1;
            end
            m_cnt   = enable ? (m_cnt + 1) % (4*SD) : 0;
            ms_rise = m_a1 && !m_a2;
            ms_nact = ms_rise || (m_act && !alarm_clr);
            if (ms_rise || !ms_nact) m_frames = 0;
            else if (!enable)        m_frames = (m_frames / BF) * BF;
            else if (ms_fe)          m_frames++;
            m_a2 = m_a1; m_a1 = alarm; m_act = ms_nact;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_seg_lz", seg_lz, e_seg_lz);
            check("model_seg_nz", seg_nz, e_seg_nz);
            check("model_an_lz",  an_lz,  e_an);
            check("model_an_nz",  an_nz,  e_an);
            check("model_dp_lz",  dp_lz,  e_dp);
            check("model_dp_nz",  dp_nz,  e_dp);
            check("model_act_lz", act_lz, m_act);
            check("model_act_nz", act_nz, m_act);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dps;
        logic [3:0][6:0] lz;
        logic [3:0][6:0] nz;
    } vec_t;

    localparam int NV = 7;
    vec_t       vecs [NV];
    logic [3:0] an_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int dark_len;
        int lit_len;
        int dis_left;

        an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
        vecs[0] = '{16'h1234, 4'h0, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        vecs[1] = '{16'h0050, 4'h0, {7'h00, 7'h00, 7'h6D, 7'h3F}, {7'h3F, 7'h3F, 7'h6D, 7'h3F}};
        vecs[2] = '{16'h0000, 4'hA, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[3] = '{16'hF0A0, 4'h5, {7'h40, 7'h3F, 7'h40, 7'h3F}, {7'h40, 7'h3F, 7'h40, 7'h3F}};
        vecs[4] = '{16'h0009, 4'h1, {7'h00, 7'h00, 7'h00, 7'h6F}, {7'h3F, 7'h3F, 7'h3F, 7'h6F}};
        vecs[5] = '{16'h0100, 4'h8, {7'h00, 7'h06, 7'h3F, 7'h3F}, {7'h3F, 7'h06, 7'h3F, 7'h3F}};
        vecs[6] = '{16'h0B78, 4'h6, {7'h00, 7'h40, 7'h07, 7'h7F}, {7'h3F, 7'h40, 7'h07, 7'h7F}};

        #1 reset = 1'b1;
        nxt();
        chk_on = 1'b1;
        check("reset_seg", seg_lz, 7'h00);
        check("reset_an",  an_lz,  4'hF);
        check("reset_dp",  dp_lz,  1'b0);
        check("reset_act", act_lz, 1'b0);

        // Scan every digit slot of each vector on both instances.
        for (int v = 0; v < NV; v++) begin
            start(vecs[v].digits, vecs[v].dps);
            nxt();
            for (int s = 0; s < 4; s++) begin
                if (s == 0) nxt();
                else repeat (4) nxt();
                check("vec_an_lz",  an_lz,  an_exp[s]);
                check("vec_an_nz",  an_nz,  an_exp[s]);
                check("vec_seg_lz", seg_lz, vecs[v].lz[s]);
                check("vec_seg_nz", seg_nz, vecs[v].nz[s]);
                check("vec_dp",     dp_lz,  vecs[v].dps[s]);
            end
        end

        // First display timing and frame-boundary capture of new digits.
        start(16'h0001, 4'h0);
        check("pre_first_an", an_lz, 4'hF);
        nxt();
        check("first_an",  an_lz,  4'hE);
        check("first_seg", seg_lz, 7'h06);
        repeat (3) nxt();
        check("slot0_last_an", an_lz, 4'hE);
        nxt();
        check("slot1_first_an", an_lz, 4'hD);
        digits_in = 16'h0099;
        nxt();
        check("no_tear_lz", seg_lz, 7'h00);
        check("no_tear_nz", seg_nz, 7'h3F);
        repeat (11) nxt();
        check("newframe_an",  an_lz,  4'hE);
        check("newframe_seg", seg_lz, 7'h6F);
        repeat (4) nxt();
        check("newframe_d1", seg_lz, 7'h6F);

        // Alarm pulse, latency, blink periods, clear.
        start(16'h1234, 4'h0);
        repeat (3) nxt();
        alarm = 1'b1;
        nxt();
        check("alarm_lat1", act_lz, 1'b0);
        alarm = 1'b0;
        nxt();
        check("alarm_lat2", act_lz, 1'b1);
        n = 0;
        while (an_lz != 4'hF && n < 200) begin nxt(); n++; end
        check("blink_dark_seen", (an_lz == 4'hF), 1'b1);
        dark_len = 0;
        while (an_lz == 4'hF && dark_len < 200) begin nxt(); dark_len++; end
        lit_len = 0;
        while (an_lz != 4'hF && lit_len < 200) begin nxt(); lit_len++; end
        check("blink_dark_len", dark_len, 32);
        check("blink_lit_len",  lit_len,  32);
        alarm_clr = 1'b1;
        nxt();
        alarm_clr = 1'b0;
        check("clr_act", act_lz, 1'b0);
        nxt();
        check("clr_lit", (an_lz != 4'hF), 1'b1);

        // Set coincident with clear, then a held level must not re-arm.
        alarm = 1'b1;
        alarm_clr = 1'b1;
        nxt();
        nxt();
        check("set_beats_clr", act_lz, 1'b1);
        alarm_clr = 1'b0;
        nxt();
        check("set_holds", act_lz, 1'b1);
        alarm_clr = 1'b1;
        nxt();
        alarm_clr = 1'b0;
        check("held_clr", act_lz, 1'b0);
        repeat (5) nxt();
        check("held_no_rearm", act_nz, 1'b0);
        alarm = 1'b0;

        // Asynchronous reset mid-scan, then enable deassert and restart.
        start(16'h1234, 4'hF);
        n = 0;
        while (an_lz != 4'hB && n < 50) begin nxt(); n++; end
        check("reach_slot2", an_lz, 4'hB);
        check("slot2_dp", dp_lz, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("async_seg", seg_lz, 7'h00);
        check("async_an",  an_lz,  4'hF);
        check("async_dp",  dp_lz,  1'b0);
        nxt();
        reset = 1'b0;
        repeat (6) nxt();
        check("presc_running", dut_lz.presc, 16'd2);
        enable = 1'b0;
        nxt();
        check("dis_an",  an_lz,  4'hF);
        check("dis_seg", seg_lz, 7'h00);
        check("dis_dp",  dp_lz,  1'b0);
        repeat (3) nxt();
        check("dis_presc", dut_lz.presc, 16'd0);
        check("dis_idx",   dut_lz.idx,   2'd0);
        enable = 1'b1;
        nxt();
        check("reen_an", an_lz, 4'hE);

        // Randomized traffic against the model.
        start(16'h0000, 4'h0);
        dis_left = 0;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            digits_in = rand_digits();
            dp_in     = 4'($urandom);
            if (dis_left > 0) begin
                dis_left--;
                enable = (dis_left == 0);
            end else if ($urandom_range(0, 149) == 0) begin
                enable   = 1'b0;
                dis_left = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 39) == 0) alarm = ~alarm;
            alarm_clr = ($urandom_range(0, 99) == 0);
            reset     = ($urandom_range(0, 799) == 0);
        end
        reset = 1'b0;
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
